// File: rtl/xmuldiv_pkg.sv
// xmuldiv_pkg: shared definitions for the HRM-CPU extension page.
//   - register offsets of the multiply/divide block (xmuldiv)
//   - CTRL and STATUS bit positions
//   - FSM state encoding used by xmuldiv_core
//   - register offsets of the neighbouring extended-ALU page
package xmuldiv_pkg;

    // Multiply/divide register map (addr[3:0])
    localparam logic [3:0] ADDR_A    = 4'd0;
    localparam logic [3:0] ADDR_B    = 4'd1;
    localparam logic [3:0] ADDR_CTRL = 4'd2;
    localparam logic [3:0] ADDR_LO   = 4'd3;
    localparam logic [3:0] ADDR_HI   = 4'd4;

    // CTRL write bits
    localparam int CTRL_MUL_BIT = 0;
    localparam int CTRL_DIV_BIT = 1;

    // STATUS read bits
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_DZ_BIT   = 1;
    localparam int STAT_DONE_BIT = 7;

    // Iteration FSM
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Extended-ALU page offsets (separate page, same decoder style)
    localparam logic [3:0] XALU_ADDR_A     = 4'd0;
    localparam logic [3:0] XALU_ADDR_B     = 4'd1;
    localparam logic [3:0] XALU_ADDR_OP    = 4'd2;
    localparam logic [3:0] XALU_ADDR_RES   = 4'd3;
    localparam logic [3:0] XALU_ADDR_FLAGS = 4'd4;

endpackage

// File: rtl/xmuldiv_if.sv
// xmuldiv_if: CPU-side memory-mapped port of the multiply/divide block.
//   addr     : CPU address, only [3:0] decoded by the slave
//   write_en : write strobe, already page-qualified
//   din      : write data
//   dout     : combinational read data
//   busy     : operation in progress
// Modports: master (CPU / testbench), slave (xmuldiv).
interface xmuldiv_if #(
    parameter int data_width = 8
);
    logic [7:0]            addr;
    logic                  write_en;
    logic [data_width-1:0] din;
    logic [data_width-1:0] dout;
    logic                  busy;

    modport master (output addr, write_en, din, input dout, busy);
    modport slave  (input addr, write_en, din, output dout, busy);
endinterface

// File: rtl/xmuldiv_core.sv
// xmuldiv_core: iterative shift-add multiplier / restoring divider.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, op_div : start request (only honoured in IDLE); 1 = divide
//   a, b          : operands (multiplier/multiplicand or dividend/divisor)
//   busy          : high while iterating
//   done          : high during the final iteration cycle; res_lo/res_hi
//                   are valid while done is high
//   res_lo/res_hi : product low/high or quotient/remainder
module xmuldiv_core
    import xmuldiv_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  op_div,
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] res_lo,
    output logic [data_width-1:0] res_hi
);
    localparam int         W    = data_width;
    localparam logic [3:0] LAST = 4'(W - 1);

    state_t         state, state_nxt;
    logic [3:0]     cnt;
    logic           div_op;
    logic [W-1:0]   r_hi;    // MUL: accumulator high half; DIV: partial remainder
    logic [W-1:0]   r_lo;    // MUL: multiplier / product low; DIV: dividend / quotient
    logic [W-1:0]   r_b;     // multiplicand or divisor
    logic [W-1:0]   hi_nxt, lo_nxt;
    logic [W:0]     addend, sum, shifted, diff;

    // One iteration of either algorithm, computed from the working registers.
    always_comb begin
        addend  = r_lo[0] ? {1'b0, r_b} : '0;
        sum     = {1'b0, r_hi} + addend;
        // The remainder is always < divisor, so W bits plus the shifted-in
        // dividend bit fit the (W+1)-bit trial.
        shifted = {r_hi, r_lo[W-1]};
        diff    = shifted - {1'b0, r_b};
        if (div_op) begin
            hi_nxt = diff[W] ? shifted[W-1:0] : diff[W-1:0];
            lo_nxt = {r_lo[W-2:0], ~diff[W]};
        end else begin
            hi_nxt = sum[W:1];
            lo_nxt = {sum[0], r_lo[W-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start)       state_nxt = RUN;
            RUN:  if (cnt == LAST) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == RUN) && (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            div_op <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_b    <= '0;
        end else if (state == IDLE && start) begin
            cnt    <= '0;
            div_op <= op_div;
            r_hi   <= '0;
            r_lo   <= a;
            r_b    <= b;
        end else if (state == RUN) begin
            cnt  <= cnt + 4'd1;
            r_hi <= hi_nxt;
            r_lo <= lo_nxt;
        end
    end

    // Results of the final iteration are handed over before they are stored.
    assign res_lo = lo_nxt;
    assign res_hi = hi_nxt;

endmodule

// File: rtl/xmuldiv.sv
// xmuldiv: memory-mapped 8-bit unsigned multiply/divide peripheral.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : xmuldiv_if slave (addr, write_en, din, dout, busy)
// Holds the A/B/result registers, the done/dz_err flags, CTRL decode and
// the combinational read mux; iteration is done in xmuldiv_core.
module xmuldiv
    import xmuldiv_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic    clk,
    input  logic    rst,
    xmuldiv_if.slave bus
);
    localparam int W = data_width;

    logic [W-1:0] a_reg, b_reg, res_lo, res_hi;
    logic         done_flag, dz_err;
    logic         core_busy, core_done, core_start;
    logic [W-1:0] core_lo, core_hi;
    logic [3:0]   addr_lo;
    logic         wr_ok, start_req, is_div, div_zero;
    logic         unused_addr_hi;

    assign addr_lo        = bus.addr[3:0];
    assign unused_addr_hi = &{1'b0, bus.addr[7:4]};

    // Writes of any kind are dropped while an operation is running.
    assign wr_ok      = bus.write_en && !core_busy;
    assign start_req  = wr_ok && (addr_lo == ADDR_CTRL) &&
                        (bus.din[CTRL_MUL_BIT] || bus.din[CTRL_DIV_BIT]);
    assign is_div     = !bus.din[CTRL_MUL_BIT];   // MUL wins if both set
    assign div_zero   = is_div && (b_reg == '0);
    assign core_start = start_req && !div_zero;

    xmuldiv_core #(.data_width(W)) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (core_start),
        .op_div (is_div),
        .a      (a_reg),
        .b      (b_reg),
        .busy   (core_busy),
        .done   (core_done),
        .res_lo (core_lo),
        .res_hi (core_hi)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            res_lo    <= '0;
            res_hi    <= '0;
            done_flag <= 1'b0;
            dz_err    <= 1'b0;
        end else begin
            if (wr_ok && addr_lo == ADDR_A) a_reg <= bus.din;
            if (wr_ok && addr_lo == ADDR_B) b_reg <= bus.din;
            if (start_req) begin
                done_flag <= 1'b0;
                dz_err    <= 1'b0;
                // Divide by zero completes immediately without entering RUN.
                if (div_zero) begin
                    res_lo    <= '1;
                    res_hi    <= a_reg;
                    dz_err    <= 1'b1;
                    done_flag <= 1'b1;
                end
            end
            if (core_done) begin
                res_lo    <= core_lo;
                res_hi    <= core_hi;
                done_flag <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.dout = '0;
        case (addr_lo)
            ADDR_A:    bus.dout = a_reg;
            ADDR_B:    bus.dout = b_reg;
            ADDR_CTRL: begin
                bus.dout[STAT_BUSY_BIT] = core_busy;
                bus.dout[STAT_DZ_BIT]   = dz_err;
                bus.dout[STAT_DONE_BIT] = done_flag;
            end
            ADDR_LO:   bus.dout = res_lo;
            ADDR_HI:   bus.dout = res_hi;
            default:   bus.dout = '0;
        endcase
    end

    assign bus.busy = core_busy;

endmodule

// File: tb/tb_xmuldiv.sv
// tb_xmuldiv: directed, table-driven bench for xmuldiv.
module tb_xmuldiv;
    import xmuldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xmuldiv_if #(.data_width(8)) bus ();
    xmuldiv #(.data_width(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] ctrl;
        logic [7:0] lo;
        logic [7:0] hi;
        logic [7:0] st;
        int         cyc;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, got, exp);
        end
    endtask

    // Drive at a falling edge, write lands on the next rising edge,
    // returns at the following falling edge.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr     = {4'h0, a};
        bus.din      = d;
        bus.write_en = 1'b1;
        @(negedge clk);
        bus.write_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bus.addr = {4'h0, a};
        #1 d = bus.dout;
    endtask

    // Counts remaining busy cycles, bounded.
    task automatic count_busy(output int c);
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.busy) break;
            c++;
            @(negedge clk);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int         c;

        vecs[0] = '{8'd13,  8'd11, 8'h01, 8'h8F, 8'h00, 8'h80, 8};
        vecs[1] = '{8'd255, 8'd255, 8'h01, 8'h01, 8'hFE, 8'h80, 8};
        vecs[2] = '{8'd0,   8'd77, 8'h01, 8'h00, 8'h00, 8'h80, 8};
        vecs[3] = '{8'd200, 8'd7,  8'h02, 8'h1C, 8'h04, 8'h80, 8};
        vecs[4] = '{8'd5,   8'd9,  8'h02, 8'h00, 8'h05, 8'h80, 8};
        vecs[5] = '{8'h2A,  8'd0,  8'h02, 8'hFF, 8'h2A, 8'h82, 0};
        vecs[6] = '{8'd13,  8'd11, 8'h03, 8'h8F, 8'h00, 8'h80, 8};

        rst          = 1'b1;
        bus.addr     = '0;
        bus.din      = '0;
        bus.write_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state at every address
        check("reset_busy", {7'b0, bus.busy}, 8'h00);
        for (int i = 0; i < 16; i++) begin
            rd(4'(i), v);
            check($sformatf("reset_rd%0d", i), v, 8'h00);
        end

        // Table of operations
        for (int k = 0; k < 7; k++) begin
            wr(ADDR_A, vecs[k].a);
            wr(ADDR_B, vecs[k].b);
            wr(ADDR_CTRL, vecs[k].ctrl);
            count_busy(c);
            check($sformatf("v%0d_busy_cycles", k), 8'(c), 8'(vecs[k].cyc));
            rd(ADDR_LO, v);   check($sformatf("v%0d_lo", k), v, vecs[k].lo);
            rd(ADDR_HI, v);   check($sformatf("v%0d_hi", k), v, vecs[k].hi);
            rd(ADDR_CTRL, v); check($sformatf("v%0d_status", k), v, vecs[k].st);
            rd(ADDR_A, v);    check($sformatf("v%0d_a_kept", k), v, vecs[k].a);
        end

        // Writes during RUN are ignored; old results readable while busy
        wr(ADDR_A, 8'd6);
        wr(ADDR_B, 8'd7);
        wr(ADDR_CTRL, 8'h01);
        check("run_busy", {7'b0, bus.busy}, 8'h01);
        rd(ADDR_CTRL, v); check("run_status", v, 8'h01);
        rd(ADDR_LO, v);   check("run_old_lo", v, 8'h8F);
        wr(ADDR_A, 8'd99);
        wr(ADDR_CTRL, 8'h02);
        count_busy(c);
        check("run_rest_cycles", 8'(c), 8'd4);
        rd(ADDR_LO, v);   check("run_lo", v, 8'h2A);
        rd(ADDR_HI, v);   check("run_hi", v, 8'h00);
        rd(ADDR_CTRL, v); check("run_status_done", v, 8'h80);
        rd(ADDR_A, v);    check("run_a_old", v, 8'd6);

        // CTRL with no start bits, and write to an unmapped address
        wr(ADDR_CTRL, 8'h00);
        check("noop_busy", {7'b0, bus.busy}, 8'h00);
        rd(ADDR_CTRL, v); check("noop_status", v, 8'h80);
        rd(ADDR_LO, v);   check("noop_lo", v, 8'h2A);
        wr(4'd5, 8'h5A);
        rd(4'd5, v);      check("unmapped_rd", v, 8'h00);

        // Reset in the middle of RUN
        wr(ADDR_A, 8'd13);
        wr(ADDR_B, 8'd11);
        wr(ADDR_CTRL, 8'h01);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", {7'b0, bus.busy}, 8'h00);
        for (int i = 0; i < 5; i++) begin
            rd(4'(i), v);
            check($sformatf("mid_rst_rd%0d", i), v, 8'h00);
        end

        // Normal operation after reset
        wr(ADDR_A, 8'd12);
        wr(ADDR_B, 8'd12);
        wr(ADDR_CTRL, 8'h01);
        count_busy(c);
        check("post_rst_cycles", 8'(c), 8'd8);
        rd(ADDR_LO, v); check("post_rst_lo", v, 8'h90);
        rd(ADDR_HI, v); check("post_rst_hi", v, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xmuldiv.md
# xmuldiv

Iterative 8-bit unsigned multiply/divide peripheral on the HRM-CPU extension page, next to the extended ALU page. The CPU writes two operands and a start command through the same memory-mapped port style, then polls status and reads a double-width product or quotient/remainder. The upstream address decoder asserts the page select; this block decodes only `addr[3:0]`. Results feed the CPU read-data mux through `dout`.

## Interface
- `data_width`, 8: operand width W. Result is 2W split into two W-bit registers.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `addr`  in  8  CPU address; only `[3:0]` decoded.
- `write_en`  in  1  write strobe, already qualified by page select.
- `din`  in  8  write data.
- `dout`  out  8  read data, combinational from `addr[3:0]` and registers.
- `busy`  out  1  operation in progress; mirrors status bit 0.

## Operation
- Register map by `addr[3:0]`:
  - 0: A operand (R/W).
  - 1: B operand (R/W).
  - 2: write CTRL (bit0 start MUL, bit1 start DIV); read STATUS {done[7], 5'b0, dz_err[1], busy[0]}.
  - 3: RES_LO (R): product low byte or quotient.
  - 4: RES_HI (R): product high byte or remainder.
  - 5–15: read 0. Writes are ignored.
- Reset: A, B, RES_LO, RES_HI, and working registers are 0; state IDLE; busy=0, done=0, dz_err=0; `dout` is 0 at every address.
- States are IDLE and RUN. A 4-bit counter `cnt` counts iterations.
- IDLE, CTRL write with bit0 or bit1 set:
  - If both bits are set, MUL wins.
  - Clear done and dz_err.
  - Load the working registers from A and B.
  - Set cnt=0 and go to RUN.
- IDLE, DIV with B=0: no RUN. At the same edge, RES_LO=all ones, RES_HI=A, dz_err=1, done=1, busy stays 0.
- MUL is shift-add. Each RUN edge examines multiplier LSB, conditionally adds the multiplicand into a 2W accumulator, then shifts.
- DIV is restoring division with a (W+1)-bit partial remainder. Each RUN edge shifts in one dividend bit, trial-subtracts B, and keeps the result if it is non-negative. The quotient bit is the inverted sign.
- Arithmetic is unsigned and exact. MUL result is the full 2W bits. DIV gives quotient = A/B and remainder = A%B.
- On the edge where cnt=W-1: write the results to RES_LO and RES_HI, set done=1, return to IDLE.
- RES_LO and RES_HI change only at completion. While busy, reads return the previous results.
- While in RUN, writes to A, B, and CTRL are ignored (no restart, no operand change).
- CTRL write with neither bit set: no effect.
- The A and B registers keep their values after an operation, so a new start can reuse them.

## Timing
- Start write at edge E0. busy=1 for cycles E0+1 through E0+W. Results, done=1, and busy=0 are visible after edge E0+W, which is W cycles of latency (8 at default).
- Divide-by-zero: results and flags are visible after E0, with 0-cycle busy.
- A write to A or B at edge E is readable at cycle E+1. `dout` has no register stage.
- A start write at the same edge as completion cannot occur, because writes during RUN are ignored. A start in the first IDLE cycle after completion is accepted.
- `rst` at any edge, including mid-RUN, overrides everything and returns all state to reset values. Partial results are discarded.

## Structure
- Shared package:
  - register offsets ADDR_A=0, ADDR_B=1, ADDR_CTRL=2, ADDR_LO=3, ADDR_HI=4;
  - CTRL and STATUS bit positions;
  - state encoding IDLE/RUN.
  - The extended-ALU page offsets live in the same package.
- Sub-module `xmuldiv_core`: datapath plus counter, with a start/op/done handshake. The top level holds the register file, CTRL decode, and read mux.

## Test plan
- Reset, then read addresses 0–15 -> all 0. Status 0x00.
- A=13, B=11, CTRL=0x01 -> busy for exactly 8 cycles. Then RES_LO=0x8F, RES_HI=0x00, status 0x80.
- A=255, B=255, MUL -> RES_LO=0x01, RES_HI=0xFE. Also A=0, B=77 -> 0x00/0x00.
- A=200, B=7, CTRL=0x02 -> quotient 0x1C, remainder 0x04. Also A=5, B=9 -> quotient 0x00, remainder 0x05.
- A=0x2A, B=0, DIV -> next cycle RES_LO=0xFF, RES_HI=0x2A, status 0x82, busy never high.
- Boundary cases:
  - During RUN, write A=99 and CTRL=0x02 -> both ignored; the original MUL result is produced, and a readback of A shows the old value.
  - CTRL=0x03 -> MUL performed.
  - `rst` at cycle 4 of RUN -> busy=0 and all registers 0 the next cycle.
